// File: rtl/gray_word_packer.sv
// gray_word_packer
//   Packs the grayscaler's 8-bit gray bytes into 16-bit words.
//   Words are buffered in a small word FIFO.
//   Each word is issued as an addressed write to the frame store over a
//   valid/ready handshake.
//   The grayscaler is throttled with pause while the FIFO nears full.
//   Frame completion is reported with a one-cycle PK_done pulse.
//
// Parameters
//   ADDR_W        width of wr_addr (word address)
//   BASE_ADDR     first word address of the frame
//   FRAME_PIXELS  gray bytes per frame (>= 1)
//   FIFO_DEPTH    word FIFO depth (power of 2, >= 4)
//
// Ports
//   clk        in   clock, all logic on rising edge
//   rst_n      in   asynchronous active-low reset
//   PK_enable  in   run enable; low aborts the frame and returns to IDLE
//   GS_valid   in   gray byte present on Din
//   Din        in   gray byte
//   wr_ready   in   frame store accepts the word this cycle
//   Dout       out  packed word (FIFO head, 0 when empty)
//   wr_addr    out  word address of Dout
//   PK_valid   out  Dout/wr_addr valid (FIFO not empty)
//   pause      out  ask the grayscaler to stop producing bytes
//   PK_done    out  one-cycle pulse once the whole frame has been written
//
// Build option
//   PK_MSB_FIRST_EN  defined: the 1st byte of a pair goes to Dout[15:8].
//                    An odd last byte is packed as {byte,8'h00}.
//                    undefined (default): LSB-first packing, i.e. {byte2,byte1}
//                    and {8'h00,byte}.
module gray_word_packer #(
  parameter int ADDR_W       = 18,
  parameter int BASE_ADDR    = 0,
  parameter int FRAME_PIXELS = 76800,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PK_enable,
  input  logic              GS_valid,
  input  logic [7:0]        Din,
  input  logic              wr_ready,
  output logic [15:0]       Dout,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              PK_valid,
  output logic              pause,
  output logic              PK_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BCNT_W = $clog2(FRAME_PIXELS + 1);

  localparam logic [CNT_W-1:0]  PAUSE_LVL = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [BCNT_W-1:0] LAST_IDX  = BCNT_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PACK  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BCNT_W-1:0] byte_cnt_q;
  logic [7:0]        half_q;
  logic              half_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pause_q, pause_d;

  logic              accept;
  logic              last_byte;
  logic              push;
  logic              pop;
  logic [15:0]       push_word;

  always_comb begin
    accept    = (state_q == PACK) && GS_valid;
    last_byte = (byte_cnt_q == LAST_IDX);
    // A word is formed on the 2nd byte of a pair, or on an unpaired final byte.
    push      = accept && (half_valid_q || last_byte);
    pop       = (count_q != '0) && wr_ready;
`ifdef PK_MSB_FIRST_EN
    push_word = half_valid_q ? {half_q, Din} : {Din, 8'h00};
`else
    push_word = half_valid_q ? {Din, half_q} : {8'h00, Din};
`endif
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = PACK;
      PACK:    if (accept && last_byte) state_d = DRAIN;
      // Leave DRAIN on the edge that pops the last word, so PK_done shows
      // in the cycle right after the final transfer.
      DRAIN:   if (count_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!PK_enable) state_d = IDLE;

    // Pause is computed from post-edge occupancy.
    // The two-word headroom absorbs bytes already in flight.
    pause_d = (state_d != PACK) || (count_d >= PAUSE_LVL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      byte_cnt_q   <= '0;
      half_q       <= 8'h00;
      half_valid_q <= 1'b0;
      addr_q       <= BASE;
      pause_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      if (state_d == IDLE) begin
        // Entering or staying in IDLE covers abort and normal completion.
        // Either way the next frame starts clean at BASE.
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        count_q      <= '0;
        byte_cnt_q   <= '0;
        half_valid_q <= 1'b0;
        addr_q       <= BASE;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          addr_q   <= addr_q + ADDR_W'(1);
        end
        if (accept) begin
          byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
          if (!half_valid_q && !last_byte) begin
            half_q       <= Din;
            half_valid_q <= 1'b1;
          end else begin
            half_valid_q <= 1'b0;
          end
        end
      end
    end
  end

  // Storage carries no reset; stale entries are never visible.
  // Dout is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_word;
  end

  assign PK_valid = (count_q != '0);
  assign Dout     = PK_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
  assign wr_addr  = addr_q;
  assign pause    = pause_q;
  assign PK_done  = (state_q == DONE);

endmodule

// File: tb/tb_gray_word_packer.sv
module tb_gray_word_packer;

  localparam int AW    = 18;
  localparam int BASE  = 0;
  localparam int FP    = 5;
  localparam int DEPTH = 4;

`ifdef PK_MSB_FIRST_EN
  localparam logic [15:0] W_T1  = 16'h1122;
  localparam logic [15:0] W_T2A = 16'h0102, W_T2B = 16'h0304, W_T2C = 16'h0500;
  localparam logic [15:0] W_T3A = 16'h3132, W_T3B = 16'h3334, W_T3C = 16'h3500;
  localparam logic [15:0] W_T4A = 16'hABCD, W_T4B = 16'h1234, W_T4C = 16'hEF00;
  localparam logic [15:0] W_T5  = 16'h6162;
`else
  localparam logic [15:0] W_T1  = 16'h2211;
  localparam logic [15:0] W_T2A = 16'h0201, W_T2B = 16'h0403, W_T2C = 16'h0005;
  localparam logic [15:0] W_T3A = 16'h3231, W_T3B = 16'h3433, W_T3C = 16'h0035;
  localparam logic [15:0] W_T4A = 16'hCDAB, W_T4B = 16'h3412, W_T4C = 16'h00EF;
  localparam logic [15:0] W_T5  = 16'h6261;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          PK_enable = 1'b0;
  logic          GS_valid = 1'b0;
  logic [7:0]    Din = 8'h00;
  logic          wr_ready = 1'b0;
  logic [15:0]   Dout;
  logic [AW-1:0] wr_addr;
  logic          PK_valid;
  logic          pause;
  logic          PK_done;

  gray_word_packer #(
    .ADDR_W(AW), .BASE_ADDR(BASE), .FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PK_enable(PK_enable), .GS_valid(GS_valid),
    .Din(Din), .wr_ready(wr_ready), .Dout(Dout), .wr_addr(wr_addr),
    .PK_valid(PK_valid), .pause(pause), .PK_done(PK_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_PACK = 1, M_DRAIN = 2, M_DONE = 3;
  int          m_phase = M_IDLE;
  logic [15:0] mq[$];
  logic [7:0]  m_bytes[$];
  int          m_nout = 0;
  logic        e_pause = 1'b0;

  function automatic logic [15:0] pack2(input logic [7:0] first, input logic [7:0] second);
`ifdef PK_MSB_FIRST_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  function automatic logic [15:0] pack1(input logic [7:0] b);
`ifdef PK_MSB_FIRST_EN
    return {b, 8'h00};
`else
    return {8'h00, b};
`endif
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    mq.delete();
    m_bytes.delete();
    m_nout  = 0;
    e_pause = 1'b0;
  endtask

  // Called exactly at each rising edge with the inputs of the ending cycle.
  task automatic model_edge();
    int n;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!PK_enable) begin
        m_phase = M_IDLE;
      end else begin
        if (mq.size() > 0 && wr_ready) begin
          void'(mq.pop_front());
          m_nout++;
        end
        case (m_phase)
          M_IDLE: m_phase = M_PACK;
          M_PACK: if (GS_valid) begin
            m_bytes.push_back(Din);
            n = m_bytes.size();
            if (n % 2 == 0) mq.push_back(pack2(m_bytes[n-2], m_bytes[n-1]));
            else if (n == FP) mq.push_back(pack1(Din));
            if (mq.size() > DEPTH) begin
              n_bad++;
              $display("FAIL fifo_overflow: got %0d words, expected at most %0d", mq.size(), DEPTH);
            end
            if (n == FP) m_phase = M_DRAIN;
          end
          M_DRAIN: if (mq.size() == 0) m_phase = M_DONE;
          default: m_phase = M_IDLE;
        endcase
      end
      if (m_phase == M_IDLE) begin
        mq.delete();
        m_bytes.delete();
        m_nout = 0;
      end
      e_pause = (m_phase != M_PACK) || (mq.size() >= DEPTH - 2);
    end
  endtask

  // ---------------- compare / record process ----------------
  int          cyc = 0;
  logic [15:0] wr_d[$];
  logic [AW-1:0] wr_a[$];
  int          wr_c[$];
  int          done_cnt = 0;
  int          done_c = 0;
  int          valid_cycles = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    cmp("PK_valid", 32'(PK_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) cmp("Dout", 32'(Dout), 32'(mq[0]));
    else if (!rst_n)   cmp("Dout_in_reset", 32'(Dout), 32'h0);
    cmp("wr_addr", 32'(wr_addr), 32'(AW'(BASE + m_nout)));
    cmp("pause", 32'(pause), 32'(e_pause));
    cmp("PK_done", 32'(PK_done), 32'(m_phase == M_DONE));
    if (PK_valid) valid_cycles++;
    if (PK_valid && wr_ready) begin
      wr_d.push_back(Dout);
      wr_a.push_back(wr_addr);
      wr_c.push_back(cyc);
    end
    if (PK_done) begin
      done_cnt++;
      done_c = cyc;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] tx_q[$];
  int         rdy_mode = 0;  // 0: never ready, 1: always ready, 2: toggle
  int         skid = 0;

  // Grayscaler stand-in: may send up to 2 bytes after pause rises.
  task automatic step();
    if (!pause) skid = 0;
    if (tx_q.size() > 0 && (!pause || skid < 2)) begin
      GS_valid = 1'b1;
      Din      = tx_q[0];
      if (pause) skid++;
    end else begin
      GS_valid = 1'b0;
      Din      = 8'h00;
    end
    case (rdy_mode)
      0:       wr_ready = 1'b0;
      1:       wr_ready = 1'b1;
      default: wr_ready = ~wr_ready;
    endcase
    @(posedge clk);
    model_edge();
    if (GS_valid) void'(tx_q.pop_front());
    #1;
  endtask

  task automatic clr();
    wr_d.delete();
    wr_a.delete();
    wr_c.delete();
    done_cnt     = 0;
    valid_cycles = 0;
  endtask

  task automatic start(input int mode);
    PK_enable = 1'b1;
    rdy_mode  = mode;
    skid      = 0;
    step();  // IDLE -> PACK edge, no byte offered
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == 0 && k < 60) begin
      step();
      k++;
    end
    if (done_cnt == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL frame_done_timeout: got no PK_done, expected one within 60 cycles");
    end
    PK_enable = 1'b0;
    step();
    step();
  endtask

  task automatic chk_wr(input string nm, input int i, input logic [15:0] d, input logic [AW-1:0] a);
    if (i >= wr_d.size()) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_missing: got %0d writes, expected write index %0d", nm, wr_d.size(), i);
    end else begin
      cmp({nm, "_data"}, 32'(wr_d[i]), 32'(d));
      cmp({nm, "_addr"}, 32'(wr_a[i]), 32'(a));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    model_reset();
    repeat (2) step();
    cmp("reset_PK_valid", 32'(PK_valid), 32'h0);
    cmp("reset_Dout", 32'(Dout), 32'h0);
    cmp("reset_wr_addr", 32'(wr_addr), 32'(BASE));
    cmp("reset_pause", 32'(pause), 32'h0);
    cmp("reset_PK_done", 32'(PK_done), 32'h0);
    rst_n = 1'b1;
    repeat (2) step();
    cmp("idle_pause", 32'(pause), 32'h1);

    // T1: single pair 11,22
    clr();
    start(1);
    tx_q = '{8'h11, 8'h22};
    repeat (6) step();
    cmp("t1_write_count", 32'(wr_d.size()), 32'd1);
    chk_wr("t1_w0", 0, W_T1, 18'd0);
    cmp("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    PK_enable = 1'b0;
    repeat (2) step();
    cmp("t1_no_done", 32'(done_cnt), 32'd0);

    // T2: full 5-byte frame, always ready
    clr();
    start(1);
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    wait_done();
    cmp("t2_write_count", 32'(wr_d.size()), 32'd3);
    chk_wr("t2_w0", 0, W_T2A, 18'd0);
    chk_wr("t2_w1", 1, W_T2B, 18'd1);
    chk_wr("t2_w2", 2, W_T2C, 18'd2);
    cmp("t2_done_count", 32'(done_cnt), 32'd1);
    cmp("t2_done_timing", 32'(done_c), 32'(wr_c.size() == 3 ? wr_c[2] + 1 : -1));

    // T3: stalled sink, pause and skid, then drain
    clr();
    start(0);
    tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    k = 0;
    while (tx_q.size() > 0 && k < 30) begin
      step();
      k++;
    end
    repeat (3) step();
    cmp("t3_no_writes_stalled", 32'(wr_d.size()), 32'd0);
    cmp("t3_pause_held", 32'(pause), 32'h1);
    cmp("t3_valid_held", 32'(PK_valid), 32'h1);
    rdy_mode = 1;
    wait_done();
    cmp("t3_write_count", 32'(wr_d.size()), 32'd3);
    chk_wr("t3_w0", 0, W_T3A, 18'd0);
    chk_wr("t3_w1", 1, W_T3B, 18'd1);
    chk_wr("t3_w2", 2, W_T3C, 18'd2);

    // T4: toggling ready
    clr();
    start(2);
    tx_q = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'hEF};
    wait_done();
    cmp("t4_write_count", 32'(wr_d.size()), 32'd3);
    chk_wr("t4_w0", 0, W_T4A, 18'd0);
    chk_wr("t4_w1", 1, W_T4B, 18'd1);
    chk_wr("t4_w2", 2, W_T4C, 18'd2);

    // T5: abort after 3 bytes, then re-enable
    clr();
    start(0);
    tx_q = '{8'h51, 8'h52, 8'h53};
    repeat (5) step();
    cmp("t5_valid_before_abort", 32'(PK_valid), 32'h1);
    PK_enable = 1'b0;
    step();
    cmp("t5_abort_valid", 32'(PK_valid), 32'h0);
    cmp("t5_abort_addr", 32'(wr_addr), 32'(BASE));
    repeat (3) step();
    cmp("t5_no_done", 32'(done_cnt), 32'd0);
    clr();
    start(1);
    tx_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    wait_done();
    cmp("t5_write_count", 32'(wr_d.size()), 32'd3);
    chk_wr("t5_w0", 0, W_T5, 18'd0);

    // T6: asynchronous reset mid-frame
    clr();
    start(0);
    tx_q = '{8'h71, 8'h72, 8'h73};
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("t6_async_valid", 32'(PK_valid), 32'h0);
    cmp("t6_async_addr", 32'(wr_addr), 32'(BASE));
    cmp("t6_async_pause", 32'(pause), 32'h0);
    PK_enable = 1'b0;
    tx_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clr();
    start(1);
    tx_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
    wait_done();
    cmp("t6_write_count", 32'(wr_d.size()), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
